// File: rtl/axis_hdr_pkg.sv
// rtl/axis_hdr_pkg.sv - shared types and keep-vector helpers for the header inserter
package axis_hdr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BODY,
        TAIL
    } state_t;

    // Widest keep vector the helpers handle (512-bit data bus)
    localparam int KEEP_MAX = 64;

    typedef logic [KEEP_MAX-1:0] keep_max_t;

    // n upper-aligned ones within a w-bit keep vector
    function automatic keep_max_t keep_top(input int n, input int w);
        keep_max_t r;
        r = '0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            if ((i < w) && (i >= w - n)) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // Number of consecutive ones from the top bit of a w-bit keep vector
    function automatic int lead_ones(input keep_max_t keep, input int w);
        int   cnt;
        logic run;
        cnt = 0;
        run = 1'b1;
        for (int i = KEEP_MAX - 1; i >= 0; i--) begin
            if (i < w) begin
                if (run && keep[i]) begin
                    cnt++;
                end else begin
                    run = 1'b0;
                end
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/axi_stream_insert_header_q_if.sv
// rtl/axi_stream_insert_header_q_if.sv - payload, header and egress stream bundle
interface axi_stream_insert_header_q_if #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
);
    logic                    valid_in;
    logic [DATA_WD-1:0]      data_in;
    logic [DATA_BYTE_WD-1:0] keep_in;
    logic                    last_in;
    logic                    ready_in;

    logic                    valid_insert;
    logic [DATA_WD-1:0]      data_insert;
    logic [BYTE_CNT_WD-1:0]  byte_insert_cnt;
    logic                    ready_insert;

    logic                    valid_out;
    logic [DATA_WD-1:0]      data_out;
    logic [DATA_BYTE_WD-1:0] keep_out;
    logic                    last_out;
    logic                    ready_out;

    // Inserter view
    modport slave (
        input  valid_in, data_in, keep_in, last_in,
        output ready_in,
        input  valid_insert, data_insert, byte_insert_cnt,
        output ready_insert,
        output valid_out, data_out, keep_out, last_out,
        input  ready_out
    );

    // Source / sink view
    modport master (
        output valid_in, data_in, keep_in, last_in,
        input  ready_in,
        output valid_insert, data_insert, byte_insert_cnt,
        input  ready_insert,
        input  valid_out, data_out, keep_out, last_out,
        output ready_out
    );
endinterface

// File: rtl/hdr_fifo.sv
// rtl/hdr_fifo.sv - synchronous header queue with full/empty flags
module hdr_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointers and storage write
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer and storage registers; storage needs no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
endmodule

// File: rtl/axi_stream_insert_header_q.sv
// rtl/axi_stream_insert_header_q.sv - prepends a queued 0..W byte header to each packet
module axi_stream_insert_header_q
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1,
    parameter int HDR_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    axi_stream_insert_header_q_if.slave   bus
);
    localparam int FIFO_WD = DATA_WD + BYTE_CNT_WD;
    localparam logic [BYTE_CNT_WD:0] W_EXT = (BYTE_CNT_WD + 1)'(DATA_BYTE_WD);

    logic                    fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic [FIFO_WD-1:0]      fifo_rdata;
    logic [DATA_WD-1:0]      head_data;
    logic [BYTE_CNT_WD-1:0]  head_cnt;

    state_t                  state_q, state_d;
    logic [BYTE_CNT_WD-1:0]  h_q, h_d;
    logic [DATA_WD-1:0]      res_q, res_d;
    logic [BYTE_CNT_WD-1:0]  tail_n_q, tail_n_d;
    logic                    valid_out_q, valid_out_d;
    logic [DATA_WD-1:0]      data_out_q, data_out_d;
    logic [DATA_BYTE_WD-1:0] keep_out_q, keep_out_d;
    logic                    last_out_q, last_out_d;

    logic                    adv, accept, ready_in_c, ready_insert_c;
    logic [BYTE_CNT_WD-1:0]  h_cur, lead_cnt;
    logic [BYTE_CNT_WD:0]    sum_hl;
    logic [DATA_WD-1:0]      prev_beat, body_beat, tail_beat;
    logic                    beat_emit, beat_last;
    logic [DATA_WD-1:0]      beat_raw;
    logic [DATA_BYTE_WD-1:0] beat_keep;

    assign fifo_push = bus.valid_insert && ready_insert_c;
    assign {head_cnt, head_data} = fifo_rdata;

    hdr_fifo #(
        .WIDTH(FIFO_WD),
        .DEPTH(HDR_DEPTH)
    ) u_hdr_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata ({bus.byte_insert_cnt, bus.data_insert}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The output register can take a new beat when empty or being drained
    assign adv      = !valid_out_q || bus.ready_out;
    assign accept   = bus.valid_in && ready_in_c;
    assign fifo_pop = accept && (state_q == IDLE);

    // At packet start the header comes straight from the queue head
    assign h_cur     = (state_q == IDLE) ? head_cnt : h_q;
    assign prev_beat = (state_q == IDLE) ? head_data : res_q;

    // Byte shifter: low H bytes of the previous word followed by top W-H bytes of the new one
    assign body_beat = DATA_WD'({prev_beat, bus.data_in} >> {h_cur, 3'b000});
    assign tail_beat = DATA_WD'({res_q, {DATA_WD{1'b0}}} >> {h_q, 3'b000});

    assign lead_cnt = BYTE_CNT_WD'(lead_ones(keep_max_t'(bus.keep_in), DATA_BYTE_WD));
    assign sum_hl   = {1'b0, h_cur} + {1'b0, lead_cnt};

    assign ready_insert_c = !rst && !fifo_full;

    // Payload acceptance depends on state and output-stage room
    always_comb begin
        ready_in_c = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE:    ready_in_c = adv && !fifo_empty;
                BODY:    ready_in_c = adv;
                default: ready_in_c = 1'b0;
            endcase
        end
    end

    // Next state, residual capture and output beat assembly
    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        res_d       = res_q;
        tail_n_d    = tail_n_q;
        valid_out_d = valid_out_q;
        data_out_d  = data_out_q;
        keep_out_d  = keep_out_q;
        last_out_d  = last_out_q;
        beat_emit   = 1'b0;
        beat_raw    = body_beat;
        beat_keep   = '1;
        beat_last   = 1'b0;

        if (adv) begin
            valid_out_d = 1'b0;
            case (state_q)
                IDLE, BODY: begin
                    if (accept) begin
                        beat_emit = 1'b1;
                        h_d       = h_cur;
                        res_d     = bus.data_in;
                        state_d   = BODY;
                        if (bus.last_in) begin
                            if (sum_hl <= W_EXT) begin
                                beat_keep = DATA_BYTE_WD'(keep_top(int'(sum_hl), DATA_BYTE_WD));
                                beat_last = 1'b1;
                                state_d   = IDLE;
                            end else begin
                                // Leftover bytes spill into one extra beat
                                tail_n_d = BYTE_CNT_WD'(sum_hl - W_EXT);
                                state_d  = TAIL;
                            end
                        end
                    end
                end
                TAIL: begin
                    beat_emit = 1'b1;
                    beat_raw  = tail_beat;
                    beat_keep = DATA_BYTE_WD'(keep_top(int'(tail_n_q), DATA_BYTE_WD));
                    beat_last = 1'b1;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // Invalid byte lanes are forced to zero
        if (beat_emit) begin
            valid_out_d = 1'b1;
            keep_out_d  = beat_keep;
            last_out_d  = beat_last;
            for (int b = 0; b < DATA_BYTE_WD; b++) begin
                data_out_d[8*b +: 8] = beat_keep[b] ? beat_raw[8*b +: 8] : 8'h00;
            end
        end
    end

    // State, residual and output stage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            h_q         <= '0;
            res_q       <= '0;
            tail_n_q    <= '0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            keep_out_q  <= '0;
            last_out_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            res_q       <= res_d;
            tail_n_q    <= tail_n_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            keep_out_q  <= keep_out_d;
            last_out_q  <= last_out_d;
        end
    end

    assign bus.ready_in     = ready_in_c;
    assign bus.ready_insert = ready_insert_c;
    assign bus.valid_out    = valid_out_q;
    assign bus.data_out     = data_out_q;
    assign bus.keep_out     = keep_out_q;
    assign bus.last_out     = last_out_q;
endmodule

// File: tb/tb_axi_stream_insert_header_q.sv
// tb/tb_axi_stream_insert_header_q.sv - directed vector bench for the header inserter
module tb_axi_stream_insert_header_q;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_stream_insert_header_q_if #(.DATA_WD(32)) bus ();

    axi_stream_insert_header_q #(
        .DATA_WD   (32),
        .HDR_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    typedef struct packed {
        logic [31:0]      hdr;
        logic [2:0]       cnt;
        logic [2:0]       nb;
        logic [2:0][31:0] din;
        logic [3:0]       lkeep;
        logic [2:0]       no;
        logic [3:0][31:0] dout;
        logic [3:0][3:0]  kout;
    } vec_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t got_q[$];
    beat_t exp_q[$];
    vec_t  tbl[8];

    always @(negedge clk) begin
        if (!rst && bus.valid_out && bus.ready_out)
            got_q.push_back({bus.data_out, bus.keep_out, bus.last_out});
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic push_hdr(input logic [31:0] d, input logic [2:0] c);
        int t;
        bus.valid_insert    = 1'b1;
        bus.data_insert     = d;
        bus.byte_insert_cnt = c;
        t = 0;
        @(negedge clk);
        while (!bus.ready_insert && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) timeout_fail("push_hdr");
        @(posedge clk); #1;
        bus.valid_insert = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int t;
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        bus.keep_in  = k;
        bus.last_in  = l;
        t = 0;
        @(negedge clk);
        while (!bus.ready_in && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) timeout_fail("send_beat");
        @(posedge clk); #1;
    endtask

    task automatic check_out(input string name);
        int t;
        t = 0;
        while (got_q.size() < exp_q.size() && t < 60) begin @(negedge clk); t++; end
        if (t >= 60) timeout_fail({name, "_wait"});
        repeat (3) @(negedge clk);
        check({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                check($sformatf("%s_b%0d_data", name, i), got_q[i].d, exp_q[i].d);
                check($sformatf("%s_b%0d_keep", name, i), got_q[i].k, exp_q[i].k);
                check($sformatf("%s_b%0d_last", name, i), got_q[i].l, exp_q[i].l);
            end
        end
        got_q.delete();
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    function automatic vec_t mkv(input logic [31:0] hdr, input logic [2:0] cnt, input logic [2:0] nb,
                                 input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                 input logic [3:0] lkeep, input logic [2:0] no,
                                 input logic [31:0] o0, input logic [3:0] k0,
                                 input logic [31:0] o1, input logic [3:0] k1,
                                 input logic [31:0] o2, input logic [3:0] k2,
                                 input logic [31:0] o3, input logic [3:0] k3);
        vec_t v;
        v.hdr = hdr; v.cnt = cnt; v.nb = nb; v.din = {d2, d1, d0};
        v.lkeep = lkeep; v.no = no; v.dout = {o3, o2, o1, o0}; v.kout = {k3, k2, k1, k0};
        return v;
    endfunction

    task automatic run_vec(input int v);
        push_hdr(tbl[v].hdr, tbl[v].cnt);
        for (int b = 0; b < int'(tbl[v].nb); b++) begin
            if (b == int'(tbl[v].nb) - 1) send_beat(tbl[v].din[b], tbl[v].lkeep, 1'b1);
            else                          send_beat(tbl[v].din[b], 4'hF, 1'b0);
        end
        bus.valid_in = 1'b0;
        for (int o = 0; o < int'(tbl[v].no); o++)
            exp_q.push_back({tbl[v].dout[o], tbl[v].kout[o], (o == int'(tbl[v].no) - 1)});
        check_out($sformatf("vec%0d", v));
    endtask

    initial begin
        tbl[0] = mkv(32'hAABBCCDD, 3, 2, 32'h11223344, 32'h55667788, 0, 4'hC, 3,
                     32'hBBCCDD11, 4'hF, 32'h22334455, 4'hF, 32'h66000000, 4'h8, 0, 0);
        tbl[1] = mkv(32'hAABBCCDD, 2, 2, 32'h11223344, 32'h55667788, 0, 4'hC, 2,
                     32'hCCDD1122, 4'hF, 32'h33445566, 4'hF, 0, 0, 0, 0);
        tbl[2] = mkv(32'hAABBCCDD, 0, 2, 32'h11223344, 32'h55667788, 0, 4'hC, 2,
                     32'h11223344, 4'hF, 32'h55660000, 4'hC, 0, 0, 0, 0);
        tbl[3] = mkv(32'h01020304, 4, 1, 32'hA1B2C3D4, 0, 0, 4'hF, 2,
                     32'h01020304, 4'hF, 32'hA1B2C3D4, 4'hF, 0, 0, 0, 0);
        tbl[4] = mkv(32'h000000EE, 1, 1, 32'hDEADBEEF, 0, 0, 4'h8, 1,
                     32'hEEDE0000, 4'hC, 0, 0, 0, 0, 0, 0);
        tbl[5] = mkv(32'h00123456, 3, 3, 32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 4'hE, 4,
                     32'h123456A0, 4'hF, 32'hA1A2A3B0, 4'hF, 32'hB1B2B3C0, 4'hF, 32'hC1C20000, 4'hC);
        tbl[6] = mkv(32'hCAFEF00D, 4, 2, 32'h01234567, 32'h89ABCDEF, 0, 4'h8, 3,
                     32'hCAFEF00D, 4'hF, 32'h01234567, 4'hF, 32'h89000000, 4'h8, 0, 0);
        tbl[7] = mkv(32'h0000BEEF, 2, 1, 32'h12345678, 0, 0, 4'hC, 1,
                     32'hBEEF1234, 4'hF, 0, 0, 0, 0, 0, 0);

        rst = 1'b1;
        bus.valid_in = 1'b0; bus.data_in = '0; bus.keep_in = '0; bus.last_in = 1'b0;
        bus.valid_insert = 1'b1; bus.data_insert = 32'h12345678; bus.byte_insert_cnt = 3'd2;
        bus.ready_out = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        bus.valid_in = 1'b1;
        @(negedge clk);
        check("rst_valid_out", bus.valid_out, 0);
        check("rst_data_out", bus.data_out, 0);
        check("rst_keep_out", bus.keep_out, 0);
        check("rst_last_out", bus.last_out, 0);
        check("rst_ready_in", bus.ready_in, 0);
        check("rst_ready_insert", bus.ready_insert, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.valid_insert = 1'b0;

        // Payload stalls with an empty header queue, then passes with one-cycle latency
        bus.data_in = 32'h0BADF00D; bus.keep_in = 4'hF; bus.last_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("empty_ready_in", bus.ready_in, 0);
            check("empty_valid_out", bus.valid_out, 0);
        end
        @(posedge clk); #1;
        push_hdr(32'hFFFFFFFF, 3'd0);
        send_beat(32'h0BADF00D, 4'hF, 1'b1);
        bus.valid_in = 1'b0;
        check("lat_valid_out", bus.valid_out, 1);
        check("lat_data_out", bus.data_out, 32'h0BADF00D);
        exp_q.push_back({32'h0BADF00D, 4'hF, 1'b1});
        check_out("stall");

        for (int v = 0; v < 8; v++) run_vec(v);

        // Fill the queue, then each packet consumes its own header in order
        push_hdr(32'h000000A1, 3'd1);
        push_hdr(32'h0000B1B2, 3'd2);
        push_hdr(32'h00C1C2C3, 3'd3);
        push_hdr(32'h99999999, 3'd0);
        @(negedge clk);
        check("full_ready_insert", bus.ready_insert, 0);
        @(posedge clk); #1;
        for (int p = 0; p < 4; p++) begin
            send_beat(32'hF0E1D2C3, 4'hF, 1'b1);
            if (p == 0) check("after_pop_ready_insert", bus.ready_insert, 1);
        end
        bus.valid_in = 1'b0;
        exp_q.push_back({32'hA1F0E1D2, 4'hF, 1'b0});
        exp_q.push_back({32'hC3000000, 4'h8, 1'b1});
        exp_q.push_back({32'hB1B2F0E1, 4'hF, 1'b0});
        exp_q.push_back({32'hD2C30000, 4'hC, 1'b1});
        exp_q.push_back({32'hC1C2C3F0, 4'hF, 1'b0});
        exp_q.push_back({32'hE1D2C300, 4'hE, 1'b1});
        exp_q.push_back({32'hF0E1D2C3, 4'hF, 1'b1});
        check_out("fifo_order");

        // Back-pressure mid-packet holds the output stage
        push_hdr(32'hAABBCCDD, 3'd3);
        send_beat(32'h11223344, 4'hF, 1'b0);
        bus.ready_out = 1'b0;
        bus.data_in = 32'h55667788; bus.keep_in = 4'hC; bus.last_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid_out", bus.valid_out, 1);
            check("bp_data_out", bus.data_out, 32'hBBCCDD11);
            check("bp_keep_out", bus.keep_out, 4'hF);
            check("bp_last_out", bus.last_out, 0);
            check("bp_ready_in", bus.ready_in, 0);
        end
        @(posedge clk); #1;
        bus.ready_out = 1'b1;
        send_beat(32'h55667788, 4'hC, 1'b1);
        bus.valid_in = 1'b0;
        exp_q.push_back({32'hBBCCDD11, 4'hF, 1'b0});
        exp_q.push_back({32'h22334455, 4'hF, 1'b0});
        exp_q.push_back({32'h66000000, 4'h8, 1'b1});
        check_out("bp");

        // Reset mid-packet drops the packet and the queued headers
        push_hdr(32'hAABBCCDD, 3'd3);
        push_hdr(32'h01020304, 3'd4);
        send_beat(32'h11223344, 4'hF, 1'b0);
        bus.data_in = 32'h55667788; bus.keep_in = 4'hC; bus.last_in = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ready_in", bus.ready_in, 0);
        check("mid_rst_ready_insert", bus.ready_insert, 0);
        @(posedge clk); #1;
        check("mid_rst_valid_out", bus.valid_out, 0);
        check("mid_rst_data_out", bus.data_out, 0);
        check("mid_rst_keep_out", bus.keep_out, 0);
        check("mid_rst_last_out", bus.last_out, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_ready_in", bus.ready_in, 0);
            check("post_rst_valid_out", bus.valid_out, 0);
        end
        check("post_rst_ready_insert", bus.ready_insert, 1);
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        check("post_rst_no_output", got_q.size(), 0);
        got_q.delete();

        // Normal operation resumes after reset
        run_vec(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
